// File: rtl/matrix_keypad_scanner_if.sv
// -----------------------------------------------------------------------------
// matrix_keypad_scanner_if
//
// Bundles the keypad matrix lines and the key hand-off handshake of
// matrix_keypad_scanner.
//
//   col_drive   [3:0]  active-low one-hot column strobe (scanner -> keypad)
//   rows        [3:0]  active-low row sense, pulled up  (keypad  -> scanner)
//   key_code    [3:0]  accepted key, code = col*4 + row (scanner -> consumer)
//   key_valid          key_code holds an unconsumed key (scanner -> consumer)
//   key_ack            consumer has taken key_code      (consumer -> scanner)
//   key_overrun        sticky: a key was dropped        (scanner -> consumer)
//
// Modports: master = scanner side, slave = keypad/consumer side.
// -----------------------------------------------------------------------------
interface matrix_keypad_scanner_if;
    logic [3:0] col_drive;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_overrun;

    modport master (
        output col_drive,
        output key_code,
        output key_valid,
        output key_overrun,
        input  rows,
        input  key_ack
    );

    modport slave (
        input  col_drive,
        input  key_code,
        input  key_valid,
        input  key_overrun,
        output rows,
        output key_ack
    );
endinterface

// File: rtl/matrix_keypad_scanner.sv
// -----------------------------------------------------------------------------
// matrix_keypad_scanner
//
// Scans a 4x4 matrix keypad one column at a time, debounces the frame-level
// result and hands accepted keys to a consumer through a valid/ack register
// with a sticky overrun flag.
//
// Parameters
//   SCAN_DIV    clock cycles per column slot (2..65535)
//   DEBOUNCE_N  identical frames needed to accept a key (1..15)
//   REPEAT_N    frames between auto-repeat emissions (1..255), only used
//               when the auto-repeat build option is enabled
//
// Ports
//   clock       rising-edge clock
//   reset       asynchronous, active-high reset
//   enable      low freezes the prescaler, column counter and key FSM
//   kp          matrix_keypad_scanner_if.master: col_drive, rows, key_code,
//               key_valid, key_ack, key_overrun
//
// Build option
//   KEYPAD_REPEAT_EN  when defined, a held key is re-emitted every REPEAT_N
//                     frames after its first acceptance.
//
// Key codes are col*4 + row; when several keys are down in one frame the
// lowest code wins.
// -----------------------------------------------------------------------------
module matrix_keypad_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 4,
    parameter int REPEAT_N   = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    matrix_keypad_scanner_if.master kp
);

    // An out-of-range configuration keeps the scanner parked rather than
    // running with truncated counters.
    localparam logic PARAMS_OK = (SCAN_DIV   >= 2) && (SCAN_DIV   <= 65535) &&
                                 (DEBOUNCE_N >= 1) && (DEBOUNCE_N <= 15)    &&
                                 (REPEAT_N   >= 1) && (REPEAT_N   <= 255);

    localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);
    localparam logic [4:0]  DEB_LAST   = 5'(DEBOUNCE_N);
`ifdef KEYPAD_REPEAT_EN
    localparam logic [8:0]  RPT_LAST   = 9'(REPEAT_N);
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // Returns {hit, code} for the lowest set bit of a 16-key map.
    function automatic logic [4:0] lowest_key(input logic [15:0] key_map);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (key_map[i]) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

    logic [3:0]  rows_p0;
    logic [3:0]  rows_p1;
    logic [15:0] presc;
    logic [1:0]  col;
    logic [11:0] frame_keys;
    logic        scan_tick;
    logic        frame_tick;
    logic [15:0] frame_map;
    logic        hit;
    logic [3:0]  res_code;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cand;
    logic [3:0]  cand_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;
    logic        emit;
    logic        restart;
`ifdef KEYPAD_REPEAT_EN
    logic [7:0]  rpt;
    logic [7:0]  rpt_n;
`endif

    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        key_overrun_q;

    // ---- Stage p0/p1: two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clock) begin
        rows_p0 <= kp.rows;
        rows_p1 <= rows_p0;
    end

    // ---- Scan timing: prescaler and column counter.
    assign scan_tick  = enable && PARAMS_OK && (presc == PRESC_LAST);
    assign frame_tick = scan_tick && (col == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
            col   <= '0;
        end else if (enable && PARAMS_OK) begin
            if (scan_tick) begin
                presc <= '0;
                col   <= col + 2'd1;
            end else begin
                presc <= presc + 16'd1;
            end
        end
    end

    assign kp.col_drive = ~(4'b0001 << col);

    // ---- Frame capture: columns 0..2 are stored; column 3 is taken straight
    // from the synchronizer so the result is ready on the column-3 tick.
    always_ff @(posedge clock) begin
        if (scan_tick) begin
            case (col)
                2'd0:    frame_keys[3:0]  <= ~rows_p1;
                2'd1:    frame_keys[7:4]  <= ~rows_p1;
                2'd2:    frame_keys[11:8] <= ~rows_p1;
                default: ;
            endcase
        end
    end

    assign frame_map       = {~rows_p1, frame_keys};
    assign {hit, res_code} = lowest_key(frame_map);

    // ---- Debounce FSM: state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cand  <= '0;
            cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rpt   <= '0;
`endif
        end else begin
            state <= state_n;
            cand  <= cand_n;
            cnt   <= cnt_n;
`ifdef KEYPAD_REPEAT_EN
            rpt   <= rpt_n;
`endif
        end
    end

    // ---- Debounce FSM: next state and emit strobe, evaluated per frame.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        cnt_n   = cnt;
        emit    = 1'b0;
        restart = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_n   = rpt;
`endif
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        restart = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!hit) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (res_code == cand) begin
                        if (({1'b0, cnt} + 5'd1) == DEB_LAST) begin
                            emit    = 1'b1;
                            state_n = HELD;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + 4'd1;
                        end
                    end else begin
                        restart = 1'b1;
                    end
                end
                HELD: begin
                    if (!hit) begin
                        state_n = IDLE;
                    end else if (res_code != cand) begin
                        restart = 1'b1;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (({1'b0, rpt} + 9'd1) == RPT_LAST) begin
                        emit  = 1'b1;
                        rpt_n = '0;
                    end else begin
                        rpt_n = rpt + 8'd1;
                    end
`endif
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase

            // A new candidate counts as its own first frame; a single-frame
            // debounce accepts it immediately.
            if (restart) begin
                cand_n = res_code;
                if (DEBOUNCE_N == 1) begin
                    emit    = 1'b1;
                    state_n = HELD;
                    cnt_n   = '0;
                end else begin
                    state_n = DEBOUNCE;
                    cnt_n   = 4'd1;
                end
            end
        end
`ifdef KEYPAD_REPEAT_EN
        if (restart || (state_n != HELD)) begin
            rpt_n = '0;
        end
`endif
    end

    // ---- Output register: emit/ack arbitration with sticky overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_overrun_q <= 1'b0;
        end else if (emit) begin
            if (!key_valid_q || kp.key_ack) begin
                key_code_q  <= cand_n;
                key_valid_q <= 1'b1;
                if (key_valid_q) begin
                    key_overrun_q <= 1'b0;
                end
            end else begin
                key_overrun_q <= 1'b1;
            end
        end else if (key_valid_q && kp.key_ack) begin
            key_valid_q   <= 1'b0;
            key_overrun_q <= 1'b0;
        end
    end

    assign kp.key_code    = key_code_q;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_overrun = key_overrun_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_matrix_keypad_scanner
//
// Drives a simulated 4x4 key matrix and compares the scanner's hand-off
// outputs, frame by frame, against a run-length model of the debounce rules.
// -----------------------------------------------------------------------------
module tb_matrix_keypad_scanner;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE_N = 3;
    localparam int REPEAT_N   = 2;
    localparam int FRAME      = 4 * SCAN_DIV;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic [15:0] pressed;

    int n_cmp;
    int n_bad;

    // Reference model state.
    logic       m_valid;
    logic [3:0] m_code;
    logic       m_ovr;
    int         m_run;
    int         m_last;

    matrix_keypad_scanner_if kp ();

    matrix_keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE_N (DEBOUNCE_N),
        .REPEAT_N   (REPEAT_N)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .kp     (kp)
    );

    always #5 clock = ~clock;

    // Passive key matrix: a pressed key pulls its row low while its column
    // is strobed.
    always_comb begin
        kp.rows = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!kp.col_drive[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (pressed[c * 4 + r]) kp.rows[r] = 1'b0;
                end
            end
        end
    end

    task automatic model_reset();
        m_valid = 1'b0;
        m_code  = 4'd0;
        m_ovr   = 1'b0;
        m_run   = 0;
        m_last  = -1;
    endtask

    // One frame of the model: ack_mode 1 = ack early in the frame,
    // 2 = ack coincident with the frame-completion edge.
    task automatic model_frame(input logic [15:0] keys, input int ack_mode);
        int  res;
        bit  em;
        res = -1;
        for (int i = 15; i >= 0; i--) if (keys[i]) res = i;
        if (ack_mode == 1 && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        if (res < 0)            m_run = 0;
        else if (res == m_last) m_run = m_run + 1;
        else                    m_run = 1;
        m_last = res;
        em = (m_run == DEBOUNCE_N);
`ifdef KEYPAD_REPEAT_EN
        if (m_run > DEBOUNCE_N && ((m_run - DEBOUNCE_N) % REPEAT_N) == 0) em = 1'b1;
`endif
        if (em) begin
            if (!m_valid || ack_mode == 2) begin
                if (m_valid) m_ovr = 1'b0;
                m_code  = 4'(res);
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (ack_mode == 2 && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endtask

    task automatic wait_col(input logic [3:0] target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (kp.col_drive === target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL col_wait: col_drive=%b never reached %b", kp.col_drive, target);
        end
    endtask

    // Called just after a frame boundary; returns just after the next one.
    task automatic run_frame(input logic [15:0] keys, input int ack_mode);
        pressed = keys;
        if (ack_mode == 1) begin
            @(negedge clock); kp.key_ack = 1'b1;
            @(negedge clock); kp.key_ack = 1'b0;
        end
        wait_col(4'b0111);
        if (ack_mode == 2) begin
            repeat (SCAN_DIV) @(negedge clock);
            kp.key_ack = 1'b1;
        end
        wait_col(4'b1110);
        kp.key_ack = 1'b0;
        model_frame(keys, ack_mode);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        wait_col(4'b0111);
        wait_col(4'b1110);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        enable      = 1'b1;
        pressed     = 16'h0;
        kp.key_ack  = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({kp.col_drive, kp.key_code, kp.key_valid, kp.key_overrun} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: col=%b code=%0d valid=%b ovr=%b, required col=1110 code=0 valid=0 ovr=0",
                     kp.col_drive, kp.key_code, kp.key_valid, kp.key_overrun);
        end
        reset = 1'b0;
        model_reset();
        wait_col(4'b0111);
        wait_col(4'b1110);
    endtask

    task automatic test_single_key();
        for (int f = 1; f <= 5; f++) begin
            run_frame(16'h0040, 0);
            n_cmp++;
            if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {m_valid, m_code, m_ovr}) begin
                n_bad++;
                $display("FAIL single_key f%0d: valid=%b code=%0d ovr=%b, required valid=%b code=%0d ovr=%b",
                         f, kp.key_valid, kp.key_code, kp.key_overrun, m_valid, m_code, m_ovr);
            end
        end
        n_cmp++;
        if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {1'b1, 4'd6, 1'b0}) begin
            n_bad++;
            $display("FAIL single_key_once: valid=%b code=%0d ovr=%b, required valid=1 code=6 ovr=0",
                     kp.key_valid, kp.key_code, kp.key_overrun);
        end
        run_frame(16'h0, 1);
    endtask

    task automatic test_bounce();
        logic [15:0] seq [6];
        seq = '{16'h0040, 16'h0040, 16'h0000, 16'h0040, 16'h0040, 16'h0040};
        for (int f = 0; f < 6; f++) begin
            run_frame(seq[f], 0);
            n_cmp++;
            if (kp.key_valid !== (f == 5) || kp.key_valid !== m_valid || kp.key_code !== m_code) begin
                n_bad++;
                $display("FAIL bounce f%0d: valid=%b code=%0d, required valid=%b code=%0d",
                         f, kp.key_valid, kp.key_code, m_valid, m_code);
            end
        end
        run_frame(16'h0, 1);
    endtask

    task automatic test_two_keys();
        for (int f = 0; f < 7; f++) begin
            if (f < 3) run_frame(16'h0240, 0);
            else       run_frame(16'h0200, (f == 3) ? 1 : 0);
            n_cmp++;
            if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {m_valid, m_code, m_ovr}) begin
                n_bad++;
                $display("FAIL two_keys f%0d: valid=%b code=%0d ovr=%b, required valid=%b code=%0d ovr=%b",
                         f, kp.key_valid, kp.key_code, kp.key_overrun, m_valid, m_code, m_ovr);
            end
            if (f == 2) begin
                n_cmp++;
                if (kp.key_code !== 4'd6) begin
                    n_bad++;
                    $display("FAIL two_keys_lowest: code=%0d, required 6", kp.key_code);
                end
            end
        end
        n_cmp++;
        if ({kp.key_valid, kp.key_code} !== {1'b1, 4'd9}) begin
            n_bad++;
            $display("FAIL two_keys_second: valid=%b code=%0d, required valid=1 code=9", kp.key_valid, kp.key_code);
        end
        run_frame(16'h0, 1);
    endtask

    task automatic test_overrun();
        for (int f = 0; f < 7; f++) begin
            run_frame((f < 3) ? 16'h0002 : ((f == 3) ? 16'h0000 : 16'h0004), 0);
            n_cmp++;
            if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {m_valid, m_code, m_ovr}) begin
                n_bad++;
                $display("FAIL overrun f%0d: valid=%b code=%0d ovr=%b, required valid=%b code=%0d ovr=%b",
                         f, kp.key_valid, kp.key_code, kp.key_overrun, m_valid, m_code, m_ovr);
            end
        end
        n_cmp++;
        if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {1'b1, 4'd1, 1'b1}) begin
            n_bad++;
            $display("FAIL overrun_flag: valid=%b code=%0d ovr=%b, required valid=1 code=1 ovr=1",
                     kp.key_valid, kp.key_code, kp.key_overrun);
        end
        run_frame(16'h0, 1);
        n_cmp++;
        if ({kp.key_valid, kp.key_overrun} !== 2'b00) begin
            n_bad++;
            $display("FAIL overrun_ack: valid=%b ovr=%b, required valid=0 ovr=0", kp.key_valid, kp.key_overrun);
        end
    endtask

    task automatic test_ack_emit_same_cycle();
        logic [15:0] seq [9];
        seq = '{16'h0008, 16'h0008, 16'h0008, 16'h1000, 16'h1000, 16'h1000,
                16'h0010, 16'h0010, 16'h0010};
        for (int f = 0; f < 9; f++) begin
            run_frame(seq[f], (f == 8) ? 2 : 0);
            n_cmp++;
            if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {m_valid, m_code, m_ovr}) begin
                n_bad++;
                $display("FAIL ack_emit f%0d: valid=%b code=%0d ovr=%b, required valid=%b code=%0d ovr=%b",
                         f, kp.key_valid, kp.key_code, kp.key_overrun, m_valid, m_code, m_ovr);
            end
        end
        n_cmp++;
        if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {1'b1, 4'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL ack_emit_final: valid=%b code=%0d ovr=%b, required valid=1 code=4 ovr=0",
                     kp.key_valid, kp.key_code, kp.key_overrun);
        end
        run_frame(16'h0, 1);
    endtask

    task automatic test_enable();
        @(negedge clock);
        enable = 1'b0;
        repeat (3 * FRAME) @(negedge clock);
        n_cmp++;
        if (kp.col_drive !== 4'b1110 || kp.key_valid !== m_valid) begin
            n_bad++;
            $display("FAIL enable_freeze: col=%b valid=%b, required col=1110 valid=%b",
                     kp.col_drive, kp.key_valid, m_valid);
        end
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            run_frame(16'h0400, 0);
            n_cmp++;
            if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {m_valid, m_code, m_ovr}) begin
                n_bad++;
                $display("FAIL enable_resume f%0d: valid=%b code=%0d ovr=%b, required valid=%b code=%0d ovr=%b",
                         f, kp.key_valid, kp.key_code, kp.key_overrun, m_valid, m_code, m_ovr);
            end
        end
        run_frame(16'h0, 1);
    endtask

    task automatic test_repeat();
        bit exp_v;
        for (int f = 1; f <= 9; f++) begin
            run_frame(16'h0020, 1);
`ifdef KEYPAD_REPEAT_EN
            exp_v = (f >= 3) && (((f - 3) % REPEAT_N) == 0);
`else
            exp_v = (f == 3);
`endif
            n_cmp++;
            if (kp.key_valid !== exp_v || kp.key_valid !== m_valid || kp.key_code !== m_code) begin
                n_bad++;
                $display("FAIL repeat f%0d: valid=%b code=%0d, required valid=%b code=%0d",
                         f, kp.key_valid, kp.key_code, exp_v, m_code);
            end
        end
        run_frame(16'h0, 1);
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int          mode;
        keys = 16'h0;
        for (int f = 0; f < 48; f++) begin
            if ($urandom_range(3) == 0) begin
                case ($urandom_range(3))
                    0:       keys = 16'h0;
                    1:       keys = 16'h1 << $urandom_range(15);
                    default: keys = (16'h1 << $urandom_range(15)) | (16'h1 << $urandom_range(15));
                endcase
            end
            mode = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(1, 2));
            run_frame(keys, mode);
            n_cmp++;
            if ({kp.key_valid, kp.key_code, kp.key_overrun} !== {m_valid, m_code, m_ovr}) begin
                n_bad++;
                $display("FAIL random f%0d keys=%h: valid=%b code=%0d ovr=%b, required valid=%b code=%0d ovr=%b",
                         f, keys, kp.key_valid, kp.key_code, kp.key_overrun, m_valid, m_code, m_ovr);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        run_frame(16'h0040, 1);
        run_frame(16'h0040, 0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({kp.col_drive, kp.key_code, kp.key_valid, kp.key_overrun} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_debounce: col=%b code=%0d valid=%b ovr=%b, required col=1110 code=0 valid=0 ovr=0",
                     kp.col_drive, kp.key_code, kp.key_valid, kp.key_overrun);
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        wait_col(4'b0111);
        wait_col(4'b1110);
        model_frame(16'h0040, 0);
        for (int f = 0; f < 3; f++) begin
            n_cmp++;
            if ({kp.key_valid, kp.key_code} !== {m_valid, m_code} || kp.key_valid !== (f == 2)) begin
                n_bad++;
                $display("FAIL reset_restart f%0d: valid=%b code=%0d, required valid=%b code=%0d",
                         f, kp.key_valid, kp.key_code, (f == 2), m_code);
            end
            if (f < 2) run_frame(16'h0040, 0);
        end
    endtask

    task automatic test_latency();
        int  cycles;
        int  key;
        bit  seen;
        pressed = 16'h0;
        do_reset();
        repeat ($urandom_range(15)) @(negedge clock);
        key     = int'($urandom_range(15));
        pressed = 16'h1 << key;
        cycles  = 0;
        seen    = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(posedge clock);
            #1;
            cycles++;
            if (kp.key_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen || cycles > (DEBOUNCE_N + 1) * FRAME + 3 || kp.key_code !== 4'(key)) begin
            n_bad++;
            $display("FAIL latency key%0d: cycles=%0d code=%0d seen=%b, required <=%0d cycles code=%0d",
                     key, cycles, kp.key_code, seen, (DEBOUNCE_N + 1) * FRAME + 3, key);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        model_reset();
        test_reset();
        test_single_key();
        test_bounce();
        test_two_keys();
        test_overrun();
        test_ack_emit_same_cycle();
        test_enable();
        test_repeat();
        test_random();
        test_reset_mid_debounce();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
